mst_win3_loader: RTL and testbench
==================================

// Module: mst_win3_loader
// PURPOSE
//   Upstream feeder for the 3-input max stage. Accepts a serial stream of
//   WIDTH-bit samples over a valid/ready handshake and assembles them into a
//   3-entry window. Presents the window as o_num_1..o_num_3 with o_vld/i_rdy,
//   so the combinational max stage consumes one complete window per accept.
//   Two modes: tumbling (disjoint triples) and sliding (overlapping triples).
// PARAMETERS
//   WIDTH  8  bit width of each sample and window entry
// PORTS
//   i_clk    in   1      clock; all state changes on the rising edge
//   i_rst_n  in   1      synchronous reset, active low
//   i_mode   in   1      0 = tumbling, 1 = sliding; sampled only when idle
//   i_clr    in   1      synchronous clear of window and count
//   i_vld    in   1      upstream sample valid
//   o_rdy    out  1      loader can take i_num this cycle
//   i_num    in   WIDTH  upstream sample
//   o_vld    out  1      window complete; o_num_1..3 stable while high
//   i_rdy    in   1      downstream (max stage) accepts the window
//   o_num_1  out  WIDTH  oldest sample in window
//   o_num_2  out  WIDTH  middle sample
//   o_num_3  out  WIDTH  newest sample
//   o_cnt    out  2      number of valid entries held (0..3)
// BEHAVIOUR
// - Reset (i_rst_n=0 at edge): w1/w2/w3=0, o_cnt=0, o_vld=0, r_mode=0; o_rdy=0 during reset.
// - States by count: EMPTY(0), PART1(1), PART2(2), FULL(3); o_vld = (state==FULL), registered.
// - Outputs o_num_1/2/3 are the w1/w2/w3 registers, no combinational path from i_num.
// - in_acc  = i_vld && o_rdy;  out_acc = o_vld && i_rdy.
// - o_rdy = i_rst_n && !i_clr && (!o_vld || i_rdy) -> 1 sample/cycle sustained.
// - On in_acc: shift w1<=w2, w2<=w3, w3<=i_num (always, all modes).
// - Transitions (no clear):
//   EMPTY/PART1/PART2 + in_acc -> count+1; no in_acc -> hold.
//   FULL, !out_acc -> hold, registers frozen (o_rdy=0).
//   FULL, out_acc, tumbling: no in_acc -> EMPTY; in_acc -> PART1.
//   FULL, out_acc, sliding:  no in_acc -> PART2; in_acc -> FULL (new window).
// - Latency: third (completing) sample accepted at edge N -> o_vld=1 after edge N.
// - i_mode latched into r_mode only at edges where state==EMPTY; changes
//   mid-window are ignored until the loader next returns to EMPTY.
// - i_clr=1: next edge -> EMPTY, w1..w3=0, o_vld=0; concurrent sample dropped
//   (o_rdy=0), concurrent out_acc irrelevant. Reset beats clear.
// - Reset or clear mid-window discards partial data; no partial window output.
// - Upstream must hold i_num/i_vld until o_rdy; i_num is don't-care when i_vld=0.
// - Sliding: each sample after the 3rd yields one window {s[k-2],s[k-1],s[k]}.
// - Tumbling: samples s0..s5 yield {s0,s1,s2} then {s3,s4,s5}; no overlap.
// TESTING
// 1 Reset: hold i_rst_n=0 2 cycles with i_vld=1 -> o_vld=0,o_cnt=0,o_num_*=0,o_rdy=0.
// 2 Tumbling, i_rdy=1, stream 5,9,3,7,2,8 back-to-back -> windows {5,9,3} then
//   {7,2,8}, o_vld 1 cycle after 3rd/6th sample, o_rdy never drops.
// 3 Sliding, i_rdy=1, stream 1,4,2,6 -> windows {1,4,2},{4,2,6} on consecutive
//   cycles; o_cnt=3 throughout.
// 4 Backpressure: tumbling, 10,20,30 loaded, i_rdy=0 for 4 cycles -> o_vld held,
//   o_num_* = {10,20,30} stable, o_rdy=0; i_rdy=1 plus i_num=40 -> o_cnt=1, w3=40.
// 5 Clear mid-window: load 0xAA,0xBB, assert i_clr with i_vld=1,i_num=0xCC ->
//   o_cnt=0, o_num_*=0, 0xCC dropped; then 1,2,3 -> window {1,2,3}.
// 6 Mode change: sliding, i_mode toggled to 0 while PART2 -> behaviour stays
//   sliding until EMPTY; boundary values 0x00/0xFF pass through unchanged.

Source files
------------

// File: rtl/mst_win3_loader_if.sv
// Window loader bus: upstream sample handshake plus downstream window handshake.
//   i_vld/o_rdy/i_num            upstream sample stream into the loader
//   o_vld/i_rdy/o_num_1..3       completed 3-entry window out to the max stage
//   o_cnt                        entries currently held by the loader (0..3)
// master: the loader side. slave: the environment (upstream source and max stage).
interface mst_win3_loader_if #(
  parameter int WIDTH = 8
);
  logic             i_vld;
  logic             o_rdy;
  logic [WIDTH-1:0] i_num;
  logic             o_vld;
  logic             i_rdy;
  logic [WIDTH-1:0] o_num_1;
  logic [WIDTH-1:0] o_num_2;
  logic [WIDTH-1:0] o_num_3;
  logic [1:0]       o_cnt;

  modport master (
    input  i_vld, i_num, i_rdy,
    output o_rdy, o_vld, o_num_1, o_num_2, o_num_3, o_cnt
  );

  modport slave (
    output i_vld, i_num, i_rdy,
    input  o_rdy, o_vld, o_num_1, o_num_2, o_num_3, o_cnt
  );
endinterface

// File: rtl/mst_win3_loader.sv
// Assembles a serial sample stream into 3-entry windows for the 3-input max
// stage. Tumbling mode emits disjoint triples; sliding mode emits one window
// per sample once three samples are held.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous reset, active low
//   i_mode   0 = tumbling, 1 = sliding; latched only while EMPTY
//   i_clr    synchronous clear of window contents and count
//   bus      mst_win3_loader_if.master (sample in, window out, o_cnt)
//
// state | meaning
// EMPTY | no samples held
// PART1 | one sample held (in w3)
// PART2 | two samples held (w2, w3)
// FULL  | complete window, o_vld high, registers frozen until accepted
module mst_win3_loader #(
  parameter int WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_mode,
  input  logic                i_clr,
  mst_win3_loader_if.master   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART1 = 2'd1,
    PART2 = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             r_mode;
  logic [WIDTH-1:0] w1;
  logic [WIDTH-1:0] w2;
  logic [WIDTH-1:0] w3;
  logic             in_acc;
  logic             out_acc;
  logic             vld;

  assign vld = (state == FULL);

  // Ready stays high while a full window is being consumed, so a new sample
  // can enter on the same edge and the stream sustains one sample per cycle.
  assign bus.o_rdy   = i_rst_n && !i_clr && (!vld || bus.i_rdy);
  assign bus.o_vld   = vld;
  assign bus.o_num_1 = w1;
  assign bus.o_num_2 = w2;
  assign bus.o_num_3 = w3;
  assign bus.o_cnt   = state;

  assign in_acc  = bus.i_vld && bus.o_rdy;
  assign out_acc = vld && bus.i_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_acc) state_nxt = PART1;
      PART1: if (in_acc) state_nxt = PART2;
      PART2: if (in_acc) state_nxt = FULL;
      FULL: begin
        if (out_acc) begin
          // Sliding keeps the two newest entries as the start of the next window.
          if (r_mode) state_nxt = in_acc ? FULL : PART2;
          else        state_nxt = in_acc ? PART1 : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (i_clr) state_nxt = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= EMPTY;
      r_mode <= 1'b0;
      w1     <= '0;
      w2     <= '0;
      w3     <= '0;
    end else begin
      state <= state_nxt;
      if (state == EMPTY) r_mode <= i_mode;
      if (i_clr) begin
        w1 <= '0;
        w2 <= '0;
        w3 <= '0;
      end else if (in_acc) begin
        w1 <= w2;
        w2 <= w3;
        w3 <= bus.i_num;
      end
    end
  end

endmodule

// File: tb/tb_mst_win3_loader.sv
// Bench for mst_win3_loader: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural model of the loader.
module tb_mst_win3_loader;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic clr;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: the last three accepted samples (oldest first), how many
  // of them form the pending window, and the mode the current window runs in.
  int m_win[3];
  int m_cnt;
  int m_mode;

  mst_win3_loader_if #(.WIDTH(WIDTH)) bus ();

  mst_win3_loader #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_mode  (mode),
    .i_clr   (clr),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_win  = '{0, 0, 0};
    m_cnt  = 0;
    m_mode = 0;
  endtask

  // One clock cycle with the given inputs. Outputs are compared at the falling
  // edge, the model advances at the rising edge, inputs may change 1 ns later.
  task automatic step(input logic r, input logic c, input logic md,
                      input logic v, input int num, input logic dr);
    int  e_vld, e_rdy, acc_in, acc_out, n_cnt;
    rst_n      = r;
    clr        = c;
    mode       = md;
    bus.i_vld  = v;
    bus.i_num  = num[WIDTH-1:0];
    bus.i_rdy  = dr;
    @(negedge clk);
    e_vld = (m_cnt == 3) ? 1 : 0;
    e_rdy = (r && !c && (e_vld == 0 || dr)) ? 1 : 0;
    chk("o_rdy", {31'd0, bus.o_rdy}, e_rdy);
    chk("o_vld", {31'd0, bus.o_vld}, e_vld);
    chk("o_cnt", {30'd0, bus.o_cnt}, m_cnt);
    chk("o_num_1", {24'd0, bus.o_num_1}, m_win[0]);
    chk("o_num_2", {24'd0, bus.o_num_2}, m_win[1]);
    chk("o_num_3", {24'd0, bus.o_num_3}, m_win[2]);
    acc_in  = (v && e_rdy) ? 1 : 0;
    acc_out = (e_vld == 1 && dr) ? 1 : 0;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      if (c) begin
        n_cnt = 0;
        m_win = '{0, 0, 0};
      end else begin
        if (acc_in == 1) m_win = '{m_win[1], m_win[2], num & 'hFF};
        if (acc_out == 1) n_cnt = (m_mode == 1) ? 2 + acc_in : acc_in;
        else              n_cnt = m_cnt + acc_in;
      end
      if (m_cnt == 0) m_mode = md;
      m_cnt = n_cnt;
    end
    #1;
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c3);
    chk({tag, "_vld"}, {31'd0, bus.o_vld}, 1);
    chk({tag, "_n1"}, {24'd0, bus.o_num_1}, a);
    chk({tag, "_n2"}, {24'd0, bus.o_num_2}, b);
    chk({tag, "_n3"}, {24'd0, bus.o_num_3}, c3);
  endtask

  initial begin
    model_reset();
    rst_n     = 1'b0;
    clr       = 1'b0;
    mode      = 1'b0;
    bus.i_vld = 1'b1;
    bus.i_num = 8'h55;
    bus.i_rdy = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with a sample offered.
    step(0, 0, 0, 1, 8'h55, 1);
    step(0, 0, 0, 1, 8'h66, 1);
    chk("rst_cnt", {30'd0, bus.o_cnt}, 0);
    chk("rst_vld", {31'd0, bus.o_vld}, 0);

    // Tumbling back-to-back stream.
    step(1, 0, 0, 1, 5, 1);
    step(1, 0, 0, 1, 9, 1);
    step(1, 0, 0, 1, 3, 1);
    chk_win("tumb_w1", 5, 9, 3);
    step(1, 0, 0, 1, 7, 1);
    chk("tumb_cnt1", {30'd0, bus.o_cnt}, 1);
    step(1, 0, 0, 1, 2, 1);
    step(1, 0, 0, 1, 8, 1);
    chk_win("tumb_w2", 7, 2, 8);
    step(1, 0, 0, 0, 0, 1);
    chk("tumb_empty", {30'd0, bus.o_cnt}, 0);

    // Sliding stream.
    step(1, 0, 1, 1, 1, 1);
    step(1, 0, 1, 1, 4, 1);
    step(1, 0, 1, 1, 2, 1);
    chk_win("slide_w1", 1, 4, 2);
    step(1, 0, 1, 1, 6, 1);
    chk_win("slide_w2", 4, 2, 6);
    chk("slide_cnt", {30'd0, bus.o_cnt}, 3);

    // Backpressure in tumbling mode.
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 10, 1);
    step(1, 0, 0, 1, 20, 1);
    step(1, 0, 0, 1, 30, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 40, 0);
      chk_win("bp_hold", 10, 20, 30);
    end
    step(1, 0, 0, 1, 40, 1);
    chk("bp_cnt", {30'd0, bus.o_cnt}, 1);
    chk("bp_w3", {24'd0, bus.o_num_3}, 40);

    // Clear mid-window with a concurrent sample.
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 8'hAA, 1);
    step(1, 0, 0, 1, 8'hBB, 1);
    step(1, 1, 0, 1, 8'hCC, 1);
    chk("clr_cnt", {30'd0, bus.o_cnt}, 0);
    chk("clr_w3", {24'd0, bus.o_num_3}, 0);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 2, 1);
    step(1, 0, 0, 1, 3, 1);
    chk_win("clr_win", 1, 2, 3);

    // Mode dropped to tumbling mid-window: sliding persists; 0x00/0xFF intact.
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 8'h00, 1);
    step(1, 0, 1, 1, 8'hFF, 1);
    step(1, 0, 0, 1, 8'hFF, 1);
    chk_win("mode_w1", 8'h00, 8'hFF, 8'hFF);
    step(1, 0, 0, 1, 8'h00, 1);
    chk_win("mode_w2", 8'hFF, 8'hFF, 8'h00);
    step(1, 0, 0, 0, 0, 1);
    chk("mode_part2", {30'd0, bus.o_cnt}, 2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
